// File: rtl/t_ctrl_wrback_pkg.sv
// Shared processor definitions used by the write-back stage.
//   CTRL_REG   : register-write descriptor {we, addr[6:0], src[1:0]}
//   wb_src_e   : write-data source select carried in CTRL_REG.src
//   wb_dest_e  : destination class decoded from a 7-bit write address
//   wb_decode  : address-map decode helper
package proc_defines;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [1:0] src;
  } CTRL_REG;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_DMEM = 2'b01,
    SRC_WREG = 2'b10,
    SRC_IMM  = 2'b11
  } wb_src_e;

  typedef enum logic [2:0] {
    DEST_DREG    = 3'd0,
    DEST_WPAR    = 3'd1,
    DEST_RADDR   = 3'd2,
    DEST_SFR     = 3'd3,
    DEST_ILLEGAL = 3'd4
  } wb_dest_e;

  // Address map: addr[6:5] selects data regs / wave params; the 100xxxx
  // window holds the SFRs with its top slot reserved for the jump address.
  localparam logic [1:0] ADDR_DREG     = 2'b00;
  localparam logic [1:0] ADDR_WPAR     = 2'b01;
  localparam logic [6:0] ADDR_RADDR    = 7'b1001111;
  localparam logic [6:0] ADDR_SFR_BASE = 7'b1000000;
  localparam logic [2:0] WP_IDX_MAX    = 3'd5;
  localparam int         WP_ENTRY_W    = 35;

  function automatic wb_dest_e wb_decode(input logic [6:0] addr);
    wb_dest_e d;
    if (addr[6:5] == ADDR_DREG)                 d = DEST_DREG;
    else if (addr[6:5] == ADDR_WPAR)            d = DEST_WPAR;
    else if (addr == ADDR_RADDR)                d = DEST_RADDR;
    else if (addr[6:4] == ADDR_SFR_BASE[6:4])   d = DEST_SFR;
    else                                        d = DEST_ILLEGAL;
    return d;
  endfunction

endpackage

// File: rtl/t_ctrl_wrback_fifo.sv
// Wave-parameter write FIFO.
//   clk_i, rst_ni : clock, async active-low reset (clears pointers only)
//   push_i/data_i : write request; accepted when not full, or when full
//                   and a pop happens in the same cycle
//   pop_i         : remove head (ignored when empty)
//   data_o        : head entry, valid while !empty_o
//   empty_o/full_o/count_o : occupancy status
module t_wrb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB
  // means full, identical pointers mean empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign data_o  = mem[rptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/t_ctrl_wrback.sv
// Write-back (WR) stage controller.
//   x2_reg_i / x2_*_dt_i : X2-stage write descriptor and candidate data
//   stall_i              : X2 held; WR is loaded with a bubble
//   wr_reg_o/wr_reg_dt_o : WR-stage descriptor and data (for forwarding)
//   dreg_* / raddr_* / sfr_* : single-cycle write strobes per destination
//   wp_*                 : wave-parameter stream out of a small FIFO
//   wp_full_o/wp_busy_o  : back-pressure and pending-write status
//   err_o                : one-cycle pulse on illegal or dropped write
// Handshake on wp_*: an entry transfers on a rising edge where
// wp_valid_o & wp_ready_i; while wp_valid_o & !wp_ready_i the index and
// data stay stable, and wp_valid_o never drops without a transfer except
// on reset.
module t_ctrl_wrback
  import proc_defines::*;
#(
  parameter int WP_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  CTRL_REG     x2_reg_i,
  input  logic [31:0] x2_alu_dt_i,
  input  logic [31:0] x2_dmem_dt_i,
  input  logic [31:0] x2_wreg_dt_i,
  input  logic [31:0] x2_imm_dt_i,
  input  logic        stall_i,
  output CTRL_REG     wr_reg_o,
  output logic [31:0] wr_reg_dt_o,
  output logic        dreg_we_o,
  output logic [4:0]  dreg_addr_o,
  output logic [31:0] dreg_dt_o,
  output logic        raddr_we_o,
  output logic [15:0] raddr_dt_o,
  output logic        sfr_we_o,
  output logic [3:0]  sfr_addr_o,
  output logic [31:0] sfr_dt_o,
  output logic        wp_valid_o,
  input  logic        wp_ready_i,
  output logic [2:0]  wp_idx_o,
  output logic [31:0] wp_dt_o,
  output logic        wp_full_o,
  output logic        wp_busy_o,
  output logic        err_o
);

  localparam int                WP_AW     = $clog2(WP_DEPTH);
  localparam logic [WP_AW:0]    CNT_EARLY = (WP_AW + 1)'(WP_DEPTH - 1);

  CTRL_REG                 wr_q;
  logic [31:0]             wr_dt_q;
  logic [31:0]             x2_dt;
  wb_dest_e                dest;
  logic                    wave_wr, wp_push, wp_pop, wp_drop, wp_bad_idx, illegal;
  logic [2:0]              wr_idx;
  logic [WP_ENTRY_W-1:0]   fifo_head;
  logic                    fifo_empty, fifo_full;
  logic [WP_AW:0]          fifo_count;

  always_comb begin
    x2_dt = x2_alu_dt_i;
    case (wb_src_e'(x2_reg_i.src))
      SRC_ALU:  x2_dt = x2_alu_dt_i;
      SRC_DMEM: x2_dt = x2_dmem_dt_i;
      SRC_WREG: x2_dt = x2_wreg_dt_i;
      SRC_IMM:  x2_dt = x2_imm_dt_i;
      default:  x2_dt = x2_alu_dt_i;
    endcase
  end

  // A stalled X2 presents the same instruction again next cycle, so the
  // stalled copies enter WR as bubbles and only the final one writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      wr_dt_q <= '0;
    end else begin
      wr_q.we   <= x2_reg_i.we & ~stall_i;
      wr_q.addr <= x2_reg_i.addr;
      wr_q.src  <= x2_reg_i.src;
      wr_dt_q   <= x2_dt;
    end
  end

  assign dest   = wb_decode(wr_q.addr);
  assign wr_idx = wr_q.addr[2:0];

  assign wr_reg_o    = wr_q;
  assign wr_reg_dt_o = wr_dt_q;

  assign dreg_we_o   = wr_q.we & (dest == DEST_DREG);
  assign dreg_addr_o = wr_q.addr[4:0];
  assign dreg_dt_o   = wr_dt_q;

  assign raddr_we_o  = wr_q.we & (dest == DEST_RADDR);
  assign raddr_dt_o  = wr_dt_q[15:0];

  assign sfr_we_o    = wr_q.we & (dest == DEST_SFR);
  assign sfr_addr_o  = wr_q.addr[3:0];
  assign sfr_dt_o    = wr_dt_q;

  assign wave_wr    = wr_q.we & (dest == DEST_WPAR);
  assign wp_push    = wave_wr & (wr_idx <= WP_IDX_MAX);
  assign wp_bad_idx = wave_wr & (wr_idx > WP_IDX_MAX);
  assign illegal    = wr_q.we & (dest == DEST_ILLEGAL);
  assign wp_pop     = wp_valid_o & wp_ready_i;
  // Full implies non-empty, so a pop this cycle always frees a slot.
  assign wp_drop    = wp_push & fifo_full & ~wp_pop;

  t_wrb_fifo #(
    .DEPTH (WP_DEPTH),
    .WIDTH (WP_ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wp_push),
    .data_i  ({wr_idx, wr_dt_q}),
    .pop_i   (wp_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign wp_valid_o = ~fifo_empty;
  // Memory is not reset; mask the head so idle outputs read as zero.
  assign wp_idx_o   = wp_valid_o ? fifo_head[34:32] : 3'd0;
  assign wp_dt_o    = wp_valid_o ? fifo_head[31:0]  : 32'd0;
  // Raised one entry early so the write already sitting in WR still fits.
  assign wp_full_o  = (fifo_count >= CNT_EARLY);
  assign wp_busy_o  = ~fifo_empty | wave_wr;
  assign err_o      = illegal | wp_bad_idx | wp_drop;

endmodule

// File: tb/tb_t_ctrl_wrback.sv
module tb_t_ctrl_wrback;
  import proc_defines::*;

  localparam int D = 4;

  logic        clk_i, rst_ni;
  CTRL_REG     x2_reg_i;
  logic [31:0] x2_alu_dt_i, x2_dmem_dt_i, x2_wreg_dt_i, x2_imm_dt_i;
  logic        stall_i;
  CTRL_REG     wr_reg_o;
  logic [31:0] wr_reg_dt_o;
  logic        dreg_we_o;
  logic [4:0]  dreg_addr_o;
  logic [31:0] dreg_dt_o;
  logic        raddr_we_o;
  logic [15:0] raddr_dt_o;
  logic        sfr_we_o;
  logic [3:0]  sfr_addr_o;
  logic [31:0] sfr_dt_o;
  logic        wp_valid_o, wp_ready_i;
  logic [2:0]  wp_idx_o;
  logic [31:0] wp_dt_o;
  logic        wp_full_o, wp_busy_o, err_o;

  t_ctrl_wrback #(.WP_DEPTH(D)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .x2_reg_i     (x2_reg_i),
    .x2_alu_dt_i  (x2_alu_dt_i),
    .x2_dmem_dt_i (x2_dmem_dt_i),
    .x2_wreg_dt_i (x2_wreg_dt_i),
    .x2_imm_dt_i  (x2_imm_dt_i),
    .stall_i      (stall_i),
    .wr_reg_o     (wr_reg_o),
    .wr_reg_dt_o  (wr_reg_dt_o),
    .dreg_we_o    (dreg_we_o),
    .dreg_addr_o  (dreg_addr_o),
    .dreg_dt_o    (dreg_dt_o),
    .raddr_we_o   (raddr_we_o),
    .raddr_dt_o   (raddr_dt_o),
    .sfr_we_o     (sfr_we_o),
    .sfr_addr_o   (sfr_addr_o),
    .sfr_dt_o     (sfr_dt_o),
    .wp_valid_o   (wp_valid_o),
    .wp_ready_i   (wp_ready_i),
    .wp_idx_o     (wp_idx_o),
    .wp_dt_o      (wp_dt_o),
    .wp_full_o    (wp_full_o),
    .wp_busy_o    (wp_busy_o),
    .err_o        (err_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // WR contents one cycle behind X2, and the wave entries still owed to
  // the consumer in order.
  logic        m_we   = 1'b0;
  logic [6:0]  m_addr = 7'd0;
  logic [1:0]  m_src  = 2'd0;
  logic [31:0] m_dt   = 32'd0;
  logic [34:0] exp_q[$];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_we = 1'b0; m_addr = 7'd0; m_src = 2'd0; m_dt = 32'd0;
      exp_q.delete();
    end else begin
      int a, idx, n_before;
      bit pop, push;
      a = int'(m_addr);
      idx = a % 8;
      n_before = exp_q.size();
      pop  = (n_before > 0) && wp_ready_i;
      push = m_we && (a >= 32) && (a < 64) && (idx < 6);
      if (pop) void'(exp_q.pop_front());
      if (push && (n_before < D || pop)) exp_q.push_back({3'(idx), m_dt});
      m_we   = x2_reg_i.we && !stall_i;
      m_addr = x2_reg_i.addr;
      m_src  = x2_reg_i.src;
      case (x2_reg_i.src)
        2'd0: m_dt = x2_alu_dt_i;
        2'd1: m_dt = x2_dmem_dt_i;
        2'd2: m_dt = x2_wreg_dt_i;
        default: m_dt = x2_imm_dt_i;
      endcase
    end
  end

  always @(negedge clk_i) begin
    int a, idx, n;
    bit is_d, is_w, is_r, is_s, is_i, push, pop, drop;
    a = int'(m_addr);
    idx = a % 8;
    n = exp_q.size();
    is_d = m_we && a < 32;
    is_w = m_we && a >= 32 && a < 64;
    is_r = m_we && a == 79;
    is_s = m_we && a >= 64 && a < 79;
    is_i = m_we && a > 79;
    push = is_w && idx < 6;
    pop  = n > 0 && wp_ready_i;
    drop = push && n == D && !pop;
    chk("wr_reg", 32'(wr_reg_o), 32'({m_we, m_addr, m_src}));
    chk("wr_dt", wr_reg_dt_o, m_dt);
    chk("dreg_we", 32'(dreg_we_o), 32'(is_d));
    chk("dreg_addr", 32'(dreg_addr_o), 32'(a % 32));
    chk("dreg_dt", dreg_dt_o, m_dt);
    chk("raddr_we", 32'(raddr_we_o), 32'(is_r));
    chk("raddr_dt", 32'(raddr_dt_o), m_dt % 32'h10000);
    chk("sfr_we", 32'(sfr_we_o), 32'(is_s));
    chk("sfr_addr", 32'(sfr_addr_o), 32'(a % 16));
    chk("sfr_dt", sfr_dt_o, m_dt);
    chk("wp_valid", 32'(wp_valid_o), 32'(n > 0));
    chk("wp_idx", 32'(wp_idx_o), (n > 0) ? 32'(exp_q[0][34:32]) : 32'd0);
    chk("wp_dt", wp_dt_o, (n > 0) ? exp_q[0][31:0] : 32'd0);
    chk("wp_full", 32'(wp_full_o), 32'(n >= D - 1));
    chk("wp_busy", 32'(wp_busy_o), 32'(n > 0 || is_w));
    chk("err", 32'(err_o), 32'(is_i || (is_w && idx >= 6) || drop));
  end

  int dreg_pulses = 0;
  always @(negedge clk_i) if (dreg_we_o === 1'b1) dreg_pulses++;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_wr(input logic [6:0] addr, input logic [1:0] src, input logic [31:0] data);
    x2_reg_i.we   = 1'b1;
    x2_reg_i.addr = addr;
    x2_reg_i.src  = src;
    x2_alu_dt_i   = (src == 2'd0) ? data : ~data;
    x2_dmem_dt_i  = (src == 2'd1) ? data : data ^ 32'h5A5A_5A5A;
    x2_wreg_dt_i  = (src == 2'd2) ? data : data ^ 32'hA5A5_0000;
    x2_imm_dt_i   = (src == 2'd3) ? data : data + 32'h0101_0101;
  endtask

  task automatic set_idle();
    x2_reg_i.we   = 1'b0;
    x2_reg_i.addr = 7'(32'($urandom_range(0, 127)));
    x2_reg_i.src  = 2'(32'($urandom_range(0, 3)));
  endtask

  logic [2:0] got[$];

  task automatic drain();
    got.delete();
    wp_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (wp_valid_o) got.push_back(wp_idx_o);
      tick();
    end
    wp_ready_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0;
    x2_reg_i = '0;
    x2_alu_dt_i = '0; x2_dmem_dt_i = '0; x2_wreg_dt_i = '0; x2_imm_dt_i = '0;
    stall_i = 1'b0;
    wp_ready_i = 1'b0;
    tick();
    chk("rst_wr_reg", 32'(wr_reg_o), 32'd0);
    chk("rst_wp_valid", 32'(wp_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic data-register write, one-cycle latency.
    set_wr(7'h05, 2'b00, 32'hDEAD_0001);
    tick();
    chk("lit_dreg_we", 32'(dreg_we_o), 32'd1);
    chk("lit_dreg_addr", 32'(dreg_addr_o), 32'd5);
    chk("lit_dreg_dt", dreg_dt_o, 32'hDEAD_0001);
    chk("lit_wr_addr", 32'(wr_reg_o.addr), 32'h05);
    set_idle();
    tick();
    chk("lit_dreg_we_off", 32'(dreg_we_o), 32'd0);

    // Each data source and the SFR window.
    set_wr(7'h1F, 2'b01, 32'hCAFE_0002); tick();
    chk("lit_dmem_dt", dreg_dt_o, 32'hCAFE_0002);
    set_wr(7'h43, 2'b10, 32'h1234_5678); tick();
    chk("lit_sfr_we", 32'(sfr_we_o), 32'd1);
    chk("lit_sfr_addr", 32'(sfr_addr_o), 32'h3);
    chk("lit_sfr_dt", sfr_dt_o, 32'h1234_5678);
    set_wr(7'h4E, 2'b11, 32'h0BAD_F00D); tick();
    chk("lit_sfr_top", 32'(sfr_addr_o), 32'hE);
    chk("lit_imm_dt", sfr_dt_o, 32'h0BAD_F00D);
    set_idle(); tick();

    // Held X2 instruction writes exactly once.
    dreg_pulses = 0;
    set_wr(7'h0A, 2'b00, 32'h1111_2222);
    stall_i = 1'b1;
    repeat (3) tick();
    stall_i = 1'b0;
    tick();
    set_idle();
    repeat (2) tick();
    chk("lit_stall_pulses", 32'(dreg_pulses), 32'd1);

    // Jump address and illegal address.
    set_wr(7'b1001111, 2'b00, 32'h0001_0123); tick();
    chk("lit_raddr_we", 32'(raddr_we_o), 32'd1);
    chk("lit_raddr_dt", 32'(raddr_dt_o), 32'h0123);
    chk("lit_raddr_no_sfr", 32'(sfr_we_o), 32'd0);
    set_wr(7'h70, 2'b00, 32'hFFFF_0000); tick();
    chk("lit_illegal_err", 32'(err_o), 32'd1);
    chk("lit_illegal_we", 32'({dreg_we_o, raddr_we_o, sfr_we_o}), 32'd0);
    set_idle(); tick();
    chk("lit_err_clear", 32'(err_o), 32'd0);

    // Fill the FIFO with no consumer, overflow, then drain in order.
    wp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_wr(7'(32'h20 + i), 2'b11, 32'hA000_0000 + 32'(i));
      tick();
      if (i == 2) chk("lit_full_early_off", 32'(wp_full_o), 32'd0);
      if (i == 3) chk("lit_full_after3", 32'(wp_full_o), 32'd1);
    end
    set_wr(7'h24, 2'b11, 32'hA000_0004); tick();
    chk("lit_drop_err", 32'(err_o), 32'd1);
    set_idle(); tick();
    chk("lit_hold_idx", 32'(wp_idx_o), 32'd0);
    chk("lit_hold_dt", wp_dt_o, 32'hA000_0000);
    drain();
    chk("lit_drain_n", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) chk("lit_drain_order", 32'(got[k]), 32'(k));

    // Index 6 is rejected.
    set_wr(7'h26, 2'b00, 32'h6666_6666); tick();
    chk("lit_idx6_err", 32'(err_o), 32'd1);
    set_idle(); tick();
    chk("lit_idx6_notpushed", 32'(wp_valid_o), 32'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      set_wr(7'(32'h38 + i), 2'b00, 32'hB000_0000 + 32'(i));
      tick();
    end
    set_wr(7'h3D, 2'b00, 32'hB000_0005); tick();
    wp_ready_i = 1'b1;
    #1 chk("lit_pushpop_err", 32'(err_o), 32'd0);
    set_idle(); tick();
    wp_ready_i = 1'b0;
    #1;
    chk("lit_pushpop_full", 32'(wp_full_o), 32'd1);
    chk("lit_pushpop_head", 32'(wp_idx_o), 32'd1);
    drain();
    chk("lit_pushpop_n", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("lit_pushpop_0", 32'(got[0]), 32'd1);
      chk("lit_pushpop_1", 32'(got[1]), 32'd2);
      chk("lit_pushpop_2", 32'(got[2]), 32'd3);
      chk("lit_pushpop_last", 32'(got[3]), 32'd5);
    end

    // Reset mid-transfer.
    set_wr(7'h21, 2'b00, 32'hC000_0001); tick();
    set_wr(7'h22, 2'b00, 32'hC000_0002); tick();
    set_idle(); tick();
    chk("lit_pre_rst_valid", 32'(wp_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("lit_async_valid", 32'(wp_valid_o), 32'd0);
    chk("lit_async_busy", 32'(wp_busy_o), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    chk("lit_post_rst_valid", 32'(wp_valid_o), 32'd0);
    chk("lit_post_rst_full", 32'(wp_full_o), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t_ctrl_wrback.md
T_CTRL_WRBACK -- requirements
Module: t_ctrl_wrback

Interface
REQ-001 SHALL have parameter WP_DEPTH, default 4, wave-parameter write FIFO depth (power of 2, 2..16).
REQ-002 SHALL have clk_i  in  1  clock; all state on rising edge.
REQ-003 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have x2_reg_i  in  CTRL_REG  X2-stage write descriptor (we, addr[6:0], src[1:0]).
REQ-005 SHALL have the following X2-stage data inputs: x2_alu_dt_i / x2_dmem_dt_i / x2_wreg_dt_i / x2_imm_dt_i, each in, 32 bits, selected by src 00/01/10/11.
REQ-006 SHALL have stall_i  in  1  pipeline hold; X2 contents repeat next cycle.
REQ-007 SHALL have wr_reg_o  out  CTRL_REG  WR-stage descriptor, consumed by forwarding logic.
REQ-008 SHALL have wr_reg_dt_o  out  32  WR-stage write data.
REQ-009 SHALL have the data register port: dreg_we_o  out  1; dreg_addr_o  out  5; dreg_dt_o  out  32.
REQ-010 SHALL have the jump-address register port: raddr_we_o  out  1; raddr_dt_o  out  16.
REQ-011 SHALL have the SFR port: sfr_we_o  out  1; sfr_addr_o  out  4; sfr_dt_o  out  32.
REQ-012 SHALL have the wave-parameter port: wp_valid_o  out  1; wp_ready_i  in  1; wp_idx_o  out  3; wp_dt_o  out  32.
REQ-013 SHALL have wp_full_o  out  1  FIFO full; upstream bubbles wave writes.
REQ-014 SHALL have wp_busy_o  out  1  wave write pending in WR or FIFO.
REQ-015 SHALL have err_o  out  1  one-cycle pulse on dropped/illegal write.

Function
REQ-016 SHALL register X2 into WR each cycle: data = src mux of REQ-005, descriptor copied; latency exactly 1 cycle.
REQ-017 SHALL load WR with we=0 when stall_i=1, so a held X2 instruction writes exactly once.
REQ-018 SHALL decode WR addr: 2'b00,[4:0] -> data reg; 2'b01,xx,[2:0] -> wave param; 7'b1001111 -> jump address; 7'b1000000-7'b1001110 -> SFR addr[3:0]; other 7'b11xxxxx -> illegal.
REQ-019 SHALL drive dreg_we_o/raddr_we_o/sfr_we_o combinationally from WR (wr_reg_o.we & decode), one cycle only per instruction.
REQ-020 SHALL write raddr_dt_o = wr_reg_dt_o[15:0]; upper bits ignored.
REQ-021 SHALL push {idx, data} into the wave FIFO on a WR wave-param write with idx 0..5; idx 6/7 are not pushed and pulse err_o.
REQ-022 SHALL present the FIFO head on wp_* with wp_valid_o = not empty; pop on wp_valid_o & wp_ready_i; data held stable while valid & !ready.
REQ-023 SHALL accept a push when full if a pop occurs in the same cycle; count unchanged.
REQ-024 SHALL drop a push when full without pop, pulse err_o, and leave FIFO contents unchanged.
REQ-025 SHALL assert wp_full_o when count == WP_DEPTH-1 or count == WP_DEPTH (one-slot early, covering the in-flight WR entry).
REQ-026 SHALL assert wp_busy_o when FIFO not empty or WR holds a wave-param write.
REQ-027 SHALL pulse err_o on illegal address with we=1; no port written.
REQ-028 SHALL use wrap-around pointers of log2(WP_DEPTH)+1 bits; full/empty from MSB compare.

Reset
REQ-029 SHALL clear, on rst_ni low at any time: WR stage (we=0, addr=0, src=0, data=0), FIFO pointers (empty), err_o; all outputs 0.
REQ-030 SHALL discard the FIFO contents and any in-flight write when reset is asserted mid-transfer; wp_valid_o falls asynchronously.

Structure
REQ-031 SHALL take CTRL_REG from the shared proc_defines package; address-map constants (DREG, WPAR, RADDR=7'b1001111, SFR base) SHALL be added there.
REQ-032 SHALL implement the wave FIFO as sub-module t_wrb_fifo (parameter DEPTH, WIDTH=35).

Verification
REQ-033 SHALL cover: X2 we=1 addr=7'h05 src=00 alu=32'hDEAD0001 -> next cycle dreg_we_o=1, addr=5, dt=32'hDEAD0001, wr_reg_o.addr=7'h05.
REQ-034 SHALL cover: stall_i=1 for 3 cycles with X2 holding a write -> exactly one dreg_we_o pulse.
REQ-035 SHALL cover: 4 wave writes idx 0..3 with wp_ready_i=0 -> wp_full_o=1 after third; fifth write dropped with err_o pulse; release ready -> idx 0,1,2,3 in order.
REQ-036 SHALL cover: FIFO full, push and pop in same cycle -> count stays 4, new entry appears last.
REQ-037 SHALL cover: addr 7'b1001111 data 32'h0001_0123 -> raddr_we_o=1, raddr_dt_o=16'h0123; addr 7'h70 -> err_o=1, no write enables.
REQ-038 SHALL cover: rst_ni low while wp_valid_o=1 -> wp_valid_o=0 immediately, FIFO empty after release.
